// File: rtl/pu_msp430_pkg.sv
// Shared definitions for the MSP430 ALU writeback stage: status register
// bit positions, writeback queue entry layout and queue occupancy states.
package pu_msp430_pkg;

    localparam int SR_C      = 0;
    localparam int SR_Z      = 1;
    localparam int SR_N      = 2;
    localparam int SR_GIE    = 3;
    localparam int SR_CPUOFF = 4;
    localparam int SR_OSCOFF = 5;
    localparam int SR_SCG0   = 6;
    localparam int SR_SCG1   = 7;
    localparam int SR_V      = 8;
    localparam int SR_W      = 9;

    localparam logic [3:0] SR_REG_IDX = 4'd2;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_TWO   = 2'd2
    } fifo_state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dst;
        logic        mem;
        logic        bw;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/pu_msp430_wb_fifo.sv
// Two-entry in-order queue between ALU capture and register/memory writeback.
// Occupancy is a registered state, so space never depends on pop combinationally.
module pu_msp430_wb_fifo
    import pu_msp430_pkg::*;
#(
    parameter int W = WB_ENTRY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         can_push,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         head_valid
);

    fifo_state_t  state;
    fifo_state_t  state_nxt;
    logic [W-1:0] ent0;
    logic [W-1:0] ent1;
    logic [W-1:0] ent0_nxt;
    logic [W-1:0] ent1_nxt;
    logic         do_push;
    logic         do_pop;

    assign can_push   = (state != FIFO_TWO);
    assign head_valid = (state != FIFO_EMPTY);
    assign head       = ent0;
    assign do_push    = push && can_push;
    assign do_pop     = pop && head_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FIFO_EMPTY;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            state <= state_nxt;
            ent0  <= ent0_nxt;
            ent1  <= ent1_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ent0_nxt  = ent0;
        ent1_nxt  = ent1;
        case (state)
            FIFO_EMPTY: begin
                if (do_push) begin
                    ent0_nxt  = push_data;
                    state_nxt = FIFO_ONE;
                end
            end
            FIFO_ONE: begin
                // simultaneous push/pop replaces the head and keeps one entry
                if (do_push && do_pop) begin
                    ent0_nxt = push_data;
                end else if (do_push) begin
                    ent1_nxt  = push_data;
                    state_nxt = FIFO_TWO;
                end else if (do_pop) begin
                    state_nxt = FIFO_EMPTY;
                end
            end
            FIFO_TWO: begin
                if (do_pop) begin
                    ent0_nxt  = ent1;
                    state_nxt = FIFO_ONE;
                end
            end
            default: begin
                state_nxt = FIFO_EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/pu_msp430_alu_wb.sv
// ALU result capture, writeback queue and status register (R2) for the MSP430 core.
// Capture flags take priority over R2 data; interrupt entry clears the mode bits last.
module pu_msp430_alu_wb
    import pu_msp430_pkg::*;
(
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        exec_cycle,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_stat,
    input  logic [3:0]  alu_stat_wr,
    input  logic        inst_bw,
    input  logic        res_wr_en,
    input  logic [3:0]  res_dst,
    input  logic        res_dst_mem,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_dst,
    output logic        wb_mem,
    output logic        wb_bw,
    input  logic        irq_sr_clr,
    output logic [15:0] sr_out,
    output logic [3:0]  status,
    output logic        gie,
    output logic        cpuoff,
    output logic        oscoff,
    output logic        scg0,
    output logic        scg1
);

    logic            capture;
    logic            r2_wr;
    wb_entry_t       new_entry;
    wb_entry_t       head_entry;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_nxt;

    assign capture = exec_cycle && res_valid && res_ready;

    always_comb begin
        new_entry.data = inst_bw ? {8'h00, alu_out[7:0]} : alu_out;
        new_entry.dst  = res_dst;
        new_entry.mem  = res_dst_mem;
        new_entry.bw   = inst_bw;
    end

    pu_msp430_wb_fifo #(
        .W(WB_ENTRY_W)
    ) u_fifo (
        .clk        (mclk),
        .rst        (puc_rst),
        .push       (capture && res_wr_en),
        .push_data  (new_entry),
        .can_push   (res_ready),
        .pop        (wb_ready),
        .head       (head_entry),
        .head_valid (wb_valid)
    );

    assign wb_data = head_entry.data;
    assign wb_dst  = head_entry.dst;
    assign wb_mem  = head_entry.mem;
    assign wb_bw   = head_entry.bw;

    assign r2_wr = wb_valid && wb_ready && !head_entry.mem && (head_entry.dst == SR_REG_IDX);

    always_comb begin
        sr_nxt = sr;
        if (r2_wr) begin
            sr_nxt = wb_data[SR_W-1:0];
        end
        if (capture) begin
            if (alu_stat_wr[0]) sr_nxt[SR_C] = alu_stat[0];
            if (alu_stat_wr[1]) sr_nxt[SR_Z] = alu_stat[1];
            if (alu_stat_wr[2]) sr_nxt[SR_N] = alu_stat[2];
            if (alu_stat_wr[3]) sr_nxt[SR_V] = alu_stat[3];
        end
        // SCG0 survives interrupt entry so the DCO setting is kept
        if (irq_sr_clr) begin
            sr_nxt[SR_GIE]    = 1'b0;
            sr_nxt[SR_CPUOFF] = 1'b0;
            sr_nxt[SR_OSCOFF] = 1'b0;
            sr_nxt[SR_SCG1]   = 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            sr <= '0;
        end else begin
            sr <= sr_nxt;
        end
    end

    assign sr_out = {{(16-SR_W){1'b0}}, sr};
    assign status = {sr[SR_V], sr[SR_N], sr[SR_Z], sr[SR_C]};
    assign gie    = sr[SR_GIE];
    assign cpuoff = sr[SR_CPUOFF];
    assign oscoff = sr[SR_OSCOFF];
    assign scg0   = sr[SR_SCG0];
    assign scg1   = sr[SR_SCG1];

endmodule

// File: tb/tb_pu_msp430_alu_wb.sv
// Bench for pu_msp430_alu_wb: scenario tasks plus a queue scoreboard that
// models occupancy and checks every writeback transfer in order.
module tb_pu_msp430_alu_wb;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        exec_cycle;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] alu_out;
    logic [3:0]  alu_stat;
    logic [3:0]  alu_stat_wr;
    logic        inst_bw;
    logic        res_wr_en;
    logic [3:0]  res_dst;
    logic        res_dst_mem;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [3:0]  wb_dst;
    logic        wb_mem;
    logic        wb_bw;
    logic        irq_sr_clr;
    logic [15:0] sr_out;
    logic [3:0]  status;
    logic        gie, cpuoff, oscoff, scg0, scg1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [21:0] sb_q[$];

    always #5 mclk = ~mclk;

    pu_msp430_alu_wb dut (
        .mclk        (mclk),
        .puc_rst     (puc_rst),
        .exec_cycle  (exec_cycle),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .alu_out     (alu_out),
        .alu_stat    (alu_stat),
        .alu_stat_wr (alu_stat_wr),
        .inst_bw     (inst_bw),
        .res_wr_en   (res_wr_en),
        .res_dst     (res_dst),
        .res_dst_mem (res_dst_mem),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_dst      (wb_dst),
        .wb_mem      (wb_mem),
        .wb_bw       (wb_bw),
        .irq_sr_clr  (irq_sr_clr),
        .sr_out      (sr_out),
        .status      (status),
        .gie         (gie),
        .cpuoff      (cpuoff),
        .oscoff      (oscoff),
        .scg0        (scg0),
        .scg1        (scg1)
    );

    // Scoreboard: inputs are stable at the falling edge, so decide transfer/capture here.
    always @(negedge mclk) begin
        logic [21:0] exp_e;
        logic        xfer;
        logic        cap;
        if (puc_rst) begin
            sb_q.delete();
        end else begin
            n_cmp++;
            if (res_ready !== (sb_q.size() != 2)) begin
                n_bad++;
                $display("FAIL sb_res_ready: got %b want %b", res_ready, sb_q.size() != 2);
            end
            n_cmp++;
            if (wb_valid !== (sb_q.size() != 0)) begin
                n_bad++;
                $display("FAIL sb_wb_valid: got %b want %b", wb_valid, sb_q.size() != 0);
            end
            if (sb_q.size() > 0) begin
                exp_e = sb_q[0];
                n_cmp++;
                if ({wb_data, wb_dst, wb_mem, wb_bw} !== exp_e) begin
                    n_bad++;
                    $display("FAIL sb_head: got data=%h dst=%0d mem=%b bw=%b want data=%h dst=%0d mem=%b bw=%b",
                             wb_data, wb_dst, wb_mem, wb_bw, exp_e[21:6], exp_e[5:2], exp_e[1], exp_e[0]);
                end
            end
            xfer = (sb_q.size() > 0) && wb_ready;
            cap  = exec_cycle && res_valid && (sb_q.size() < 2);
            if (xfer) void'(sb_q.pop_front());
            if (cap && res_wr_en)
                sb_q.push_back({inst_bw ? {8'h00, alu_out[7:0]} : alu_out, res_dst, res_dst_mem, inst_bw});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] st, input logic [3:0] stw,
                         input logic bw, input logic wen, input logic [3:0] dst, input logic mem);
        res_valid   = 1'b1;
        alu_out     = d;
        alu_stat    = st;
        alu_stat_wr = stw;
        inst_bw     = bw;
        res_wr_en   = wen;
        res_dst     = dst;
        res_dst_mem = mem;
    endtask

    task automatic idle();
        res_valid   = 1'b0;
        alu_stat_wr = 4'h0;
        irq_sr_clr  = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        n_cmp++; if (sr_out !== 16'h0000) begin n_bad++; $display("FAIL rst_sr: got %h want 0000", sr_out); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
        n_cmp++; if ({wb_data, wb_dst, wb_mem, wb_bw} !== 22'h0) begin n_bad++;
            $display("FAIL rst_head: got %h/%h/%b/%b want 0", wb_data, wb_dst, wb_mem, wb_bw); end
        n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL rst_res_ready: got %b want 1", res_ready); end
        puc_rst = 1'b0;
        step(1);
    endtask

    task automatic test_add();
        wb_ready = 1'b1;
        offer(16'h8000, 4'b1100, 4'hF, 1'b0, 1'b1, 4'd5, 1'b0);
        step(1);
        idle();
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", wb_valid); end
        n_cmp++; if (wb_data !== 16'h8000) begin n_bad++; $display("FAIL add_data: got %h want 8000", wb_data); end
        n_cmp++; if (wb_dst !== 4'd5) begin n_bad++; $display("FAIL add_dst: got %0d want 5", wb_dst); end
        n_cmp++; if (status !== 4'b1100) begin n_bad++; $display("FAIL add_status: got %b want 1100", status); end
        n_cmp++; if (sr_out !== 16'h0104) begin n_bad++; $display("FAIL add_sr: got %h want 0104", sr_out); end
        step(2);
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b0;
        offer(16'h1111, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd4, 1'b0);
        step(1);
        offer(16'h2222, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd6, 1'b1);
        step(1);
        n_cmp++; if (res_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: got %b want 0", res_ready); end
        offer(16'h3333, 4'b1111, 4'hF, 1'b0, 1'b1, 4'd7, 1'b0);
        step(1);
        idle();
        n_cmp++; if (status !== 4'b1100) begin n_bad++; $display("FAIL b2b_noflag: got %b want 1100", status); end
        n_cmp++; if (wb_data !== 16'h1111) begin n_bad++; $display("FAIL b2b_hold: got %h want 1111", wb_data); end
        wb_ready = 1'b1;
        step(1);
        n_cmp++; if (wb_data !== 16'h2222) begin n_bad++; $display("FAIL b2b_second: got %h want 2222", wb_data); end
        step(1);
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", wb_valid); end
        n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", res_ready); end
    endtask

    task automatic test_byte();
        wb_ready = 1'b1;
        exec_cycle = 1'b0;
        offer(16'hABCD, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd8, 1'b0);
        step(1);
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL noexec_valid: got %b want 0", wb_valid); end
        exec_cycle = 1'b1;
        offer(16'h12F0, 4'b0000, 4'h0, 1'b1, 1'b1, 4'd9, 1'b0);
        step(1);
        idle();
        n_cmp++; if (wb_data !== 16'h00F0) begin n_bad++; $display("FAIL byte_data: got %h want 00F0", wb_data); end
        n_cmp++; if (wb_bw !== 1'b1) begin n_bad++; $display("FAIL byte_bw: got %b want 1", wb_bw); end
        step(1);
    endtask

    task automatic test_sr_r2();
        wb_ready = 1'b1;
        offer(16'h01FF, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd2, 1'b0);
        step(1);
        idle();
        step(1);
        n_cmp++; if (sr_out !== 16'h01FF) begin n_bad++; $display("FAIL r2_sr: got %h want 01FF", sr_out); end
        n_cmp++; if ({gie, cpuoff, oscoff, scg0, scg1} !== 5'b11111) begin n_bad++;
            $display("FAIL r2_bits: got %b want 11111", {gie, cpuoff, oscoff, scg0, scg1}); end
        irq_sr_clr = 1'b1;
        step(1);
        irq_sr_clr = 1'b0;
        n_cmp++; if (sr_out !== 16'h0147) begin n_bad++; $display("FAIL irq_sr: got %h want 0147", sr_out); end
        n_cmp++; if ({gie, cpuoff, oscoff, scg0, scg1} !== 5'b00010) begin n_bad++;
            $display("FAIL irq_bits: got %b want 00010", {gie, cpuoff, oscoff, scg0, scg1}); end
        n_cmp++; if (status !== 4'b1111) begin n_bad++; $display("FAIL irq_status: got %b want 1111", status); end
    endtask

    task automatic test_r2_capture_conflict();
        wb_ready = 1'b0;
        offer(16'h0000, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd2, 1'b0);
        step(1);
        wb_ready = 1'b1;
        offer(16'hFFFF, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'd3, 1'b0);
        step(1);
        idle();
        n_cmp++; if (sr_out !== 16'h0001) begin n_bad++; $display("FAIL conflict_sr: got %h want 0001", sr_out); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL flagonly_fifo: got %b want 0", wb_valid); end
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b1;
        offer(16'h01FF, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd2, 1'b0);
        step(1);
        idle();
        step(1);
        wb_ready = 1'b0;
        offer(16'h5A5A, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd3, 1'b0);
        step(1);
        offer(16'hA5A5, 4'b0000, 4'h0, 1'b1, 1'b1, 4'd5, 1'b1);
        step(1);
        n_cmp++; if (res_ready !== 1'b0 || sr_out !== 16'h01FF) begin n_bad++;
            $display("FAIL prerst: got ready=%b sr=%h want ready=0 sr=01FF", res_ready, sr_out); end
        puc_rst    = 1'b1;
        wb_ready   = 1'b1;
        irq_sr_clr = 1'b1;
        offer(16'h0003, 4'b1111, 4'hF, 1'b0, 1'b1, 4'd2, 1'b0);
        step(1);
        n_cmp++; if (sr_out !== 16'h0000) begin n_bad++; $display("FAIL midrst_sr: got %h want 0000", sr_out); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", wb_valid); end
        n_cmp++; if (res_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", res_ready); end
        n_cmp++; if (wb_data !== 16'h0000) begin n_bad++; $display("FAIL midrst_data: got %h want 0000", wb_data); end
        puc_rst = 1'b0;
        idle();
        step(2);
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL postrst_valid: got %b want 0", wb_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        puc_rst     = 1'b1;
        exec_cycle  = 1'b1;
        res_valid   = 1'b0;
        alu_out     = 16'h0000;
        alu_stat    = 4'h0;
        alu_stat_wr = 4'h0;
        inst_bw     = 1'b0;
        res_wr_en   = 1'b0;
        res_dst     = 4'd0;
        res_dst_mem = 1'b0;
        wb_ready    = 1'b0;
        irq_sr_clr  = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_byte();
        test_sr_r2();
        test_r2_capture_conflict();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
